// File: rtl/frog_pkg.sv
// Shared types and geometry constants for the frog movement path.
// Direction and hop-state enums, plus the priority picker used on key vectors.
package frog_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    HOP,
    COOLDOWN
  } hop_state_t;

  localparam int FROG_STEP_PX = 2;
  localparam int FROG_CELL_PX = 20;

  // Key vector bit order: {right, left, down, up}; up wins, right loses.
  function automatic dir_t prio_dir(input logic [3:0] k);
    dir_t d;
    if (k[0])      d = DIR_UP;
    else if (k[1]) d = DIR_DOWN;
    else if (k[2]) d = DIR_LEFT;
    else if (k[3]) d = DIR_RIGHT;
    else           d = DIR_NONE;
    return d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle tick every DIV cycles.
// First tick appears DIV cycles after reset release.
module tick_prescaler #(
  parameter int DIV = 500000
) (
  input  logic CLK,
  input  logic RESETn,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Turns raw key levels into fixed-length hops with cooldown, auto-repeat and a
// one-deep tap buffer; all state transitions are aligned to the movement tick.
module frog_hop_ctrl
  import frog_pkg::*;
#(
  parameter int TICK_DIV       = 500000,
  parameter int HOP_TICKS      = FROG_CELL_PX / FROG_STEP_PX,
  parameter int COOLDOWN_TICKS = 5
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  input  logic reset_position,
  output logic timer_done,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic hop_busy,
  output logic hop_done
);

  localparam int MAX_TICKS = (HOP_TICKS > COOLDOWN_TICKS) ? HOP_TICKS : COOLDOWN_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] HOP_LAST = CW'(HOP_TICKS - 1);
  localparam logic [CW-1:0] CD_LAST  = CW'(COOLDOWN_TICKS - 1);

  logic [3:0]    keys, sync1, sync2, prev, rise;
  hop_state_t    state_q, state_d;
  dir_t          dir_q, dir_d, pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .CLK    (CLK),
    .RESETn (RESETn),
    .tick   (timer_done)
  );

  assign keys = {key_right, key_left, key_down, key_up};
  assign rise = sync2 & ~prev;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (reset_position) begin
      state_d = IDLE;
      dir_d   = DIR_NONE;
      pend_d  = DIR_NONE;
      cnt_d   = '0;
    end else begin
      if (pend_q == DIR_NONE && rise != 4'b0) pend_d = prio_dir(rise);
      if (timer_done) begin
        unique case (state_q)
          IDLE: begin
            if (pend_q != DIR_NONE || sync2 != 4'b0) begin
              state_d = HOP;
              dir_d   = (pend_q != DIR_NONE) ? pend_q : prio_dir(sync2);
              pend_d  = DIR_NONE;
              cnt_d   = '0;
            end
          end
          HOP: begin
            // This tick is the last one the position register sees the direction on.
            if (cnt_q == HOP_LAST) begin
              state_d = COOLDOWN;
              dir_d   = DIR_NONE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          COOLDOWN: begin
            if (cnt_q == CD_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      dir_q    <= DIR_NONE;
      pend_q   <= DIR_NONE;
      cnt_q    <= '0;
      hop_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      hop_done <= done_d;
    end
  end

  assign up       = (dir_q == DIR_UP);
  assign down     = (dir_q == DIR_DOWN);
  assign left     = (dir_q == DIR_LEFT);
  assign right    = (dir_q == DIR_RIGHT);
  assign hop_busy = (state_q != IDLE);

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed scenarios plus random key traffic against a tick-level model of the
// hop rules: each busy period is HOP+COOLDOWN ticks, direction visible for the first HOP.
module tb_frog_hop_ctrl;

  localparam int TDIV = 4;
  localparam int HOPT = 10;
  localparam int CDT  = 2;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rp   = 1'b0;
  logic [3:0] keyv = 4'b0;
  logic       timer_done, up, down, left, right, hop_busy, hop_done;

  int tests = 0;
  int fails = 0;

  // Model: n = clock edges since reset release, kh[i] = raw keys sampled at edge i.
  int         n      = 0;
  int         remain = 0;
  int         m_dir  = 0;
  int         m_pend = 0;
  bit         m_done = 1'b0;
  logic [3:0] kh [0:8191];
  int         tick_cnt [1:4];
  int         done_cnt = 0;
  int         first;

  always #5 clk = ~clk;

  frog_hop_ctrl #(
    .TICK_DIV       (TDIV),
    .HOP_TICKS      (HOPT),
    .COOLDOWN_TICKS (CDT)
  ) dut (
    .CLK            (clk),
    .RESETn         (rstn),
    .key_up         (keyv[0]),
    .key_down       (keyv[1]),
    .key_left       (keyv[2]),
    .key_right      (keyv[3]),
    .reset_position (rp),
    .timer_done     (timer_done),
    .up             (up),
    .down           (down),
    .left           (left),
    .right          (right),
    .hop_busy       (hop_busy),
    .hop_done       (hop_done)
  );

  // 1=up 2=down 3=left 4=right, 0=none
  function automatic int prio(input logic [3:0] k);
    if (k[0]) return 1;
    if (k[1]) return 2;
    if (k[2]) return 3;
    if (k[3]) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] khv(input int i);
    return (i < 1) ? 4'b0 : kh[i];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int d = 1; d <= 4; d++) tick_cnt[d] = 0;
    done_cnt = 0;
  endtask

  task automatic step();
    logic [3:0] kin, held, rise;
    logic [6:0] exp;
    bit         rpin, tick_now;
    int         pold, vis;
    kin      = keyv;
    rpin     = rp;
    held     = khv(n - 1);
    rise     = held & ~khv(n - 2);
    tick_now = (n > 0) && (n % TDIV == 0);
    pold     = m_pend;
    @(posedge clk);
    m_done = 1'b0;
    if (rpin) begin
      remain = 0;
      m_dir  = 0;
      m_pend = 0;
    end else begin
      if (m_pend == 0 && rise != 4'b0) m_pend = prio(rise);
      if (tick_now) begin
        if (remain == 0) begin
          if (pold != 0 || held != 4'b0) begin
            m_dir  = (pold != 0) ? pold : prio(held);
            m_pend = 0;
            remain = HOPT + CDT;
          end
        end else begin
          remain--;
          if (remain == CDT) m_done = 1'b1;
        end
      end
    end
    n++;
    kh[n] = kin;
    #1;
    vis = (remain > CDT) ? m_dir : 0;
    exp = {(n % TDIV == 0), (vis == 1), (vis == 2), (vis == 3), (vis == 4), (remain > 0), m_done};
    chk("outputs", {1'b0, timer_done, up, down, left, right, hop_busy, hop_done}, {1'b0, exp});
    chk("onehot", 8'($countones({up, down, left, right}) <= 1), 8'd1);
    if (timer_done) begin
      if (up)    tick_cnt[1]++;
      if (down)  tick_cnt[2]++;
      if (left)  tick_cnt[3]++;
      if (right) tick_cnt[4]++;
    end
    if (hop_done) done_cnt++;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) kh[i] = 4'b0;
    clr();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {1'b0, timer_done, up, down, left, right, hop_busy, hop_done}, 8'd0);
    rstn = 1'b1;
    n    = 0;

    // idle prescaler, first tick position
    first = 0;
    for (int i = 0; i < 20 && first == 0; i++) begin
      step();
      if (timer_done) first = n;
    end
    chk("first_tick", 8'(first), 8'd4);
    run(10);

    // single-cycle up tap between ticks
    while (n % TDIV != 1) step();
    clr();
    keyv = 4'b0001;
    step();
    keyv = 4'b0000;
    run(70);
    chk("tap_up_ticks", 8'(tick_cnt[1]), 8'd10);
    chk("tap_up_other", 8'(tick_cnt[2] + tick_cnt[3] + tick_cnt[4]), 8'd0);
    chk("tap_up_done", 8'(done_cnt), 8'd1);

    // held left auto-repeats in whole hops
    clr();
    keyv = 4'b0100;
    run(120);
    keyv = 4'b0000;
    run(80);
    chk("left_whole_hops", 8'(tick_cnt[3] % 10), 8'd0);
    chk("left_repeats", 8'(tick_cnt[3] >= 20), 8'd1);
    chk("left_done_cnt", 8'(done_cnt), 8'(tick_cnt[3] / 10));

    // simultaneous up+right: up wins, right dropped
    clr();
    keyv = 4'b1001;
    step();
    keyv = 4'b0000;
    run(70);
    chk("simul_up", 8'(tick_cnt[1]), 8'd10);
    chk("simul_right", 8'(tick_cnt[4]), 8'd0);

    // down tap during a left hop is buffered
    clr();
    keyv = 4'b0100;
    run(2);
    keyv = 4'b0000;
    run(12);
    keyv = 4'b0010;
    run(2);
    keyv = 4'b0000;
    run(130);
    chk("buf_left", 8'(tick_cnt[3]), 8'd10);
    chk("buf_down", 8'(tick_cnt[2]), 8'd10);
    chk("buf_done", 8'(done_cnt), 8'd2);

    // abort mid-hop
    clr();
    keyv = 4'b0001;
    run(2);
    keyv = 4'b0000;
    for (int i = 0; i < 200 && tick_cnt[1] < 4; i++) step();
    chk("abort_reach", 8'(tick_cnt[1]), 8'd4);
    run(2);
    rp = 1'b1;
    step();
    rp = 1'b0;
    run(20);
    chk("abort_up_ticks", 8'(tick_cnt[1]), 8'd4);
    chk("abort_no_done", 8'(done_cnt), 8'd0);
    chk("abort_idle", 8'(hop_busy), 8'd0);
    clr();
    keyv = 4'b0010;
    run(8);
    keyv = 4'b0000;
    run(70);
    chk("after_abort_down", 8'(tick_cnt[2]), 8'd10);
    chk("after_abort_done", 8'(done_cnt), 8'd1);

    // random key traffic with occasional aborts
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) keyv[$urandom_range(0, 3)] ^= 1'b1;
      rp = ($urandom_range(0, 199) == 0);
      step();
    end
    rp   = 1'b0;
    keyv = 4'b0000;
    run(80);

    // asynchronous reset in the middle of a right hop
    rp = 1'b1;
    step();
    rp = 1'b0;
    run(4);
    keyv = 4'b1000;
    run(20);
    chk("pre_arst_right", 8'(right), 8'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_outputs", {1'b0, timer_done, up, down, left, right, hop_busy, hop_done}, 8'd0);
    keyv = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frog_hop_ctrl.md
Name: frog_hop_ctrl

Overview:
Upstream stage of the frog position register. It converts raw player key levels into discrete, fixed-length hops and generates the movement tick (timer_done) that the position register consumes. A hop holds exactly one direction output high for HOP_TICKS consecutive ticks, so the frog moves a whole cell per press. Each hop is followed by a cooldown. Held keys auto-repeat, and one tap pressed during a busy period is buffered.

Parameters:
TICK_DIV, 500000, clock cycles per movement tick (50 MHz / 100 Hz); minimum 2
HOP_TICKS, 10, ticks per hop (10 x 2 px = one 20 px frog cell); minimum 1
COOLDOWN_TICKS, 5, idle ticks enforced after each hop; minimum 1

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
key_up  in  1  raw key level, asynchronous to CLK
key_down  in  1  raw key level
key_left  in  1  raw key level
key_right  in  1  raw key level
reset_position  in  1  synchronous hop abort (frog death / level restart)
timer_done  out  1  one-cycle movement tick
up  out  1  direction level to the position register
down  out  1  direction level
left  out  1  direction level
right  out  1  direction level
hop_busy  out  1  high in HOP or COOLDOWN
hop_done  out  1  one-cycle pulse when a hop completes normally

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler 0, pending empty, synchronizers 0.
- Prescaler: free-running counter 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - timer_done is registered and high for the one cycle after the count equals TICK_DIV-1.
  - The first pulse occurs TICK_DIV cycles after reset release.
  - reset_position does not affect the prescaler.
- Keys: each key passes through a 2-flop synchronizer, then rising-edge detection on the synchronized value.
- Priority for simultaneous keys: up > down > left > right.
- Pending buffer: one deep.
  - Loads the highest-priority rising edge when empty.
  - Further edges are dropped while it is full.
  - Cleared when its hop starts.
- FSM (all transitions occur only in cycles where timer_done=1):
  - IDLE: if pending is valid, or any synchronized key is held, go to HOP. Direction = pending direction if valid, else the highest-priority held key. Clear hop_cnt.
  - HOP: the selected direction output is high from the cycle after entry and stays stable between ticks. Each tick increments hop_cnt. On the tick where hop_cnt reaches HOP_TICKS, go to COOLDOWN; the direction output drops and hop_done pulses in the following cycle. The position register therefore samples the direction high on exactly HOP_TICKS ticks.
  - COOLDOWN: count COOLDOWN_TICKS ticks, then go to IDLE. A new hop can start at the next tick at the earliest.
- At most one direction output is high at any time.
- hop_busy is asserted in HOP and COOLDOWN.
- reset_position=1 (any state, any cycle):
  - Next cycle: state IDLE, direction outputs 0, pending cleared, counters cleared, no hop_done.
  - While it is held, no hop starts and no pending load occurs.
- Key release mid-hop does not shorten the hop. A key still held at the end of cooldown starts a new hop (auto-repeat).
- Asynchronous reset mid-hop returns all outputs to 0 immediately.

Decomposition:
- frog_pkg holds:
  - dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - hop_state_t enum {IDLE, HOP, COOLDOWN}
  - constants FROG_STEP_PX=2 and FROG_CELL_PX=20; HOP_TICKS defaults to FROG_CELL_PX/FROG_STEP_PX
- One sub-module, tick_prescaler (param DIV; ports CLK, RESETn, tick), also reused by other timed game objects.

Test Plan (TICK_DIV=4, HOP_TICKS=10, COOLDOWN_TICKS=2):
- Reset release, no keys -> timer_done pulses every 4 cycles, first at cycle 4; all direction outputs and hop_busy stay 0.
- key_up held for 1 cycle between ticks -> pending captures it; up is high across exactly 10 timer_done pulses; hop_done pulses once; hop_busy falls 2 ticks later.
- key_left held continuously -> left is high on 10 ticks, low on 2 cooldown ticks plus the IDLE entry tick, then repeats; never overlaps another direction.
- key_up and key_right rise in the same cycle in IDLE -> up is chosen; right is dropped.
- key_down pressed during a left hop, then released -> left completes 10 ticks; after cooldown a down hop of 10 ticks follows from pending.
- reset_position asserted at tick 5 of an up hop -> up falls next cycle; hop_done stays 0; state IDLE; a key held afterwards starts a fresh 10-tick hop.
